// File: rtl/dcache_flush_unit.sv
// Data-cache flush sequencer: sweeps every set, writes back dirty ways, then clears metadata.
// Define DCACHE_FLUSH_INVALIDATE_EN for clean-and-invalidate; otherwise only dirty state is cleared.
module dcache_flush_unit #(
    parameter int NUM_SETS = 256,
    parameter int NUM_WAYS = 8
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic                                            flush_i,
    output logic                                            flush_ack_o,
    output logic                                            busy_o,
    output logic                                            meta_req_o,
    output logic [$clog2(NUM_SETS)-1:0]                     meta_idx_o,
    input  logic                                            meta_gnt_i,
    input  logic [NUM_WAYS-1:0]                             meta_dirty_i,
    output logic                                            meta_we_o,
    output logic [NUM_WAYS-1:0]                             meta_clr_o,
    output logic                                            wb_valid_o,
    output logic [$clog2(NUM_SETS)-1:0]                     wb_idx_o,
    output logic [((NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1)-1:0] wb_way_o,
    input  logic                                            wb_ready_i
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WB,
        CLR,
        NEXT,
        ACK,
        DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [NUM_WAYS-1:0] pend_q, pend_d;
    logic [NUM_WAYS-1:0] dirty_q, dirty_d;

    logic [WAY_W-1:0]    low_way;
    logic [NUM_WAYS-1:0] low_oh;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            dirty_q <= dirty_d;
        end
    end

    // Lowest-index pending way; descending scan so the smallest set bit wins.
    always_comb begin
        low_way = '0;
        low_oh  = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (pend_q[w]) begin
                low_way   = WAY_W'(w);
                low_oh    = '0;
                low_oh[w] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        dirty_d     = dirty_q;
        flush_ack_o = 1'b0;
        busy_o      = (state_q != IDLE);
        meta_req_o  = 1'b0;
        meta_idx_o  = '0;
        meta_we_o   = 1'b0;
        meta_clr_o  = '0;
        wb_valid_o  = 1'b0;
        wb_idx_o    = '0;
        wb_way_o    = '0;

        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    cnt_d   = '0;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                meta_req_o = 1'b1;
                meta_idx_o = cnt_q;
                if (meta_gnt_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                pend_d  = meta_dirty_i;
                dirty_d = meta_dirty_i;
                state_d = (meta_dirty_i != '0) ? WB : CLR;
            end
            WB: begin
                wb_valid_o = 1'b1;
                wb_idx_o   = cnt_q;
                wb_way_o   = low_way;
                if (wb_ready_i) begin
                    pend_d = pend_q & ~low_oh;
                    if ((pend_q & ~low_oh) == '0) state_d = CLR;
                end
            end
            CLR: begin
                meta_we_o  = 1'b1;
                meta_idx_o = cnt_q;
`ifdef DCACHE_FLUSH_INVALIDATE_EN
                meta_clr_o = '1;
`else
                meta_clr_o = dirty_q;
`endif
                if (meta_gnt_i) state_d = NEXT;
            end
            NEXT: begin
                if (cnt_q == IDX_W'(NUM_SETS - 1)) begin
                    state_d = ACK;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = RD_REQ;
                end
            end
            ACK: begin
                flush_ack_o = 1'b1;
                state_d     = DRAIN;
            end
            DRAIN: begin
                if (!flush_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
